rv_pipe: RTL

- Parametrised valid/ready pipeline of STAGES register slices between one master and one slave.
- Successor to the single-stage forward-registered slice.
- MODE selects one of two slice types:
  - forward slice: registers valid and data only;
  - full skid slice: registers valid, data and ready, which breaks every combinational path between the ports.
- Adds a synchronous flush and an occupancy count, for retiming long valid/ready routes across the design.

---
 rtl/rv_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rv_pipe.sv
// rv_pipe: a chain of STAGES valid/ready register slices between one master
// and one slave. It is used to retime long valid/ready routes.
//
// MODE selects the slice type:
//   0 = forward slice. Valid and data are registered; ready stays combinational.
//   1 = full skid slice. Valid, data and ready are all registered.
// It also provides a synchronous flush and a registered occupancy count.
//
// Ports:
//   clk, rst                : rising-edge clock, async active-low reset
//   flush                   : synchronous clear of every held item
//   datain/_val/_rdy        : upstream (slave side of this block)
//   dataout/_val/_rdy       : downstream (master side of this block)
//   occupancy               : number of items currently held

// rv_slice: one register slice.
//   in_val/in_data/in_rdy    : input side
//   out_val/out_data/out_rdy : output side
module rv_slice #(
    parameter int WD   = 4,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_val,
    input  logic [WD-1:0] in_data,
    output logic          in_rdy,
    output logic          out_val,
    output logic [WD-1:0] out_data,
    input  logic          out_rdy
);
    if (MODE == 0) begin : g_fwd
        logic          v;
        logic [WD-1:0] d;

        assign in_rdy   = out_rdy || !v;
        assign out_val  = v;
        assign out_data = d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v <= 1'b0;
                d <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (in_rdy) begin
                v <= in_val;
                if (in_val) d <= in_data;
            end
        end
    end else begin : g_skid
        logic          m_v, s_v;
        logic [WD-1:0] m_d, s_d;
        logic          in_fire, main_free;

        // Ready comes only from the skid flag, so no combinational path crosses the slice.
        assign in_rdy    = !s_v;
        assign in_fire   = in_val && !s_v;
        assign main_free = !m_v || out_rdy;
        assign out_val   = m_v;
        assign out_data  = m_d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
                m_d <= '0;
                s_d <= '0;
            end else if (flush) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
            end else if (main_free) begin
                // The skid item is older than any new input, so it refills main first.
                // in_rdy is low while s_v is set, so no accept can happen at the same edge.
                if (s_v) begin
                    m_v <= 1'b1;
                    m_d <= s_d;
                    s_v <= 1'b0;
                end else if (in_fire) begin
                    m_v <= 1'b1;
                    m_d <= in_data;
                end else begin
                    m_v <= 1'b0;
                end
            end else if (in_fire) begin
                s_v <= 1'b1;
                s_d <= in_data;
            end
        end
    end
endmodule

module rv_pipe #(
    parameter int WD     = 4,
    parameter int STAGES = 2,
    parameter int MODE   = 0,
    parameter int OCC_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WD-1:0]    datain,
    input  logic             datain_val,
    output logic             datain_rdy,
    output logic [WD-1:0]    dataout,
    output logic             dataout_val,
    input  logic             dataout_rdy,
    output logic [OCC_W-1:0] occupancy
);
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("rv_pipe: MODE must be 0 or 1");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("rv_pipe: STAGES must be 1..8");
    end
    if ((1 << OCC_W) <= 2 * STAGES) begin : g_bad_occw
        $error("rv_pipe: OCC_W too narrow for capacity");
    end

    logic [STAGES:0]         val;
    logic [STAGES:0][WD-1:0] data;

    assign val[0]  = datain_val;
    assign data[0] = datain;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Each slice has its own ready signals. In MODE 0 the backward ready
        // chain would then not be seen as one self-dependent vector.
        logic rdy_in;
        logic rdy_out;

        if (k == STAGES - 1) begin : g_last
            assign rdy_out = dataout_rdy;
        end else begin : g_mid
            assign rdy_out = g_st[k+1].rdy_in;
        end

        rv_slice #(.WD(WD), .MODE(MODE)) u_slice (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_val   (val[k]),
            .in_data  (data[k]),
            .in_rdy   (rdy_in),
            .out_val  (val[k+1]),
            .out_data (data[k+1]),
            .out_rdy  (rdy_out)
        );
    end

    assign datain_rdy  = g_st[0].rdy_in;
    assign dataout     = data[STAGES];
    assign dataout_val = val[STAGES];

    logic in_xfer, out_xfer;
    assign in_xfer  = datain_val && datain_rdy;
    assign out_xfer = dataout_val && dataout_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
endmodule
